// File: rtl/reg_bank_flags_pkg.sv
// Shared datapath constants: default operand width, register-file address width
// and the hardwired-zero register address.
package reg_bank_flags_pkg;

   localparam int WIDTH_DEF  = 4;
   localparam int ADDR_W_DEF = 4;
   localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_bank_flags_flag_reg.sv
// Enabled multi-bit register with async active-low reset; holds ALU condition
// flags here and is shared with the control unit for its condition latch.
module flag_reg #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] flags_q;
   logic [W-1:0] flags_d;

   always_comb begin
      flags_d = flags_q;
      if (en_i) flags_d = d_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   assign q_o = flags_q;

endmodule

// File: rtl/reg_bank_flags.sv
// Operand register bank (R0 hardwired to zero, two combinational read ports,
// no write bypass) plus the zero/carry/sign flag register.
module reg_bank_flags
   import reg_bank_flags_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we3,
   input  logic [ADDR_W-1:0] wa3,
   input  logic [WIDTH-1:0]  wd3,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic              flags_we,
   input  logic              zero_in,
   input  logic              carry_in,
   input  logic              sign_in,
   output logic              zero_q,
   output logic              carry_q,
   output logic              sign_q
);

   localparam int NREGS = 2**ADDR_W;

   // No storage for R0: the array starts at index 1.
   logic [WIDTH-1:0] regs_q [1:NREGS-1];
   logic [WIDTH-1:0] regs_d [1:NREGS-1];
   logic [2:0]       flags_q;

   always_comb begin
      for (int i = ZERO_REG + 1; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (we3 && (wa3 == ADDR_W'(i))) regs_d[i] = wd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = ZERO_REG + 1; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = ZERO_REG + 1; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int i = ZERO_REG + 1; i < NREGS; i++) begin
         if (ra1 == ADDR_W'(i)) rd1 = regs_q[i];
         if (ra2 == ADDR_W'(i)) rd2 = regs_q[i];
      end
   end

   flag_reg #(.W(3)) u_flag_reg (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (flags_we),
      .d_i   ({zero_in, carry_in, sign_in}),
      .q_o   (flags_q)
   );

   assign {zero_q, carry_q, sign_q} = flags_q;

endmodule

// File: tb/tb_reg_bank_flags.sv
// Directed bench: stimulus pushes the expected read ports and flags for the
// current cycle; a monitor pops and compares at each falling clock edge.
module tb_reg_bank_flags;

   logic       clk;
   logic       reset;
   logic       we3;
   logic [3:0] wa3;
   logic [3:0] wd3;
   logic [3:0] ra1;
   logic [3:0] ra2;
   logic [3:0] rd1;
   logic [3:0] rd2;
   logic       flags_we;
   logic       zero_in;
   logic       carry_in;
   logic       sign_in;
   logic       zero_q;
   logic       carry_q;
   logic       sign_q;

   typedef struct {
      string      tag;
      logic [3:0] e1;
      logic [3:0] e2;
      logic [2:0] ef;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   reg_bank_flags dut (
      .clk      (clk),
      .reset    (reset),
      .we3      (we3),
      .wa3      (wa3),
      .wd3      (wd3),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2),
      .flags_we (flags_we),
      .zero_in  (zero_in),
      .carry_in (carry_in),
      .sign_in  (sign_in),
      .zero_q   (zero_q),
      .carry_q  (carry_q),
      .sign_q   (sign_q)
   );

   // Starts high so the first falling edge precedes the first rising edge.
   initial clk = 1'b1;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t it;
         it = exp_q.pop_front();
         checks++;
         if (rd1 !== it.e1 || rd2 !== it.e2 || {zero_q, carry_q, sign_q} !== it.ef) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h zcs=%b, want rd1=%h rd2=%h zcs=%b",
                     it.tag, rd1, rd2, {zero_q, carry_q, sign_q}, it.e1, it.e2, it.ef);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [2:0] ef);
      exp_t it;
      it.tag = tag;
      it.e1  = e1;
      it.e2  = e2;
      it.ef  = ef;
      exp_q.push_back(it);
   endtask

   // Register contents just before the sweep: R3=9, R7=6, R15=8.
   logic [3:0] pre_sweep [16] = '{4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h6,
                                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};

   initial begin
      reset = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
      flags_we = 1'b0; zero_in = 1'b0; carry_in = 1'b0; sign_in = 1'b0;
      ra1 = 4'd5; ra2 = 4'd15;
      expect_out("reset_state", 4'h0, 4'h0, 3'b000);

      step(); reset = 1'b1;
      expect_out("reset_release", 4'h0, 4'h0, 3'b000);

      step(); we3 = 1'b1; wa3 = 4'd3; wd3 = 4'h9; ra1 = 4'd3; ra2 = 4'd3;
      expect_out("wr_no_bypass", 4'h0, 4'h0, 3'b000);
      step(); we3 = 1'b0;
      expect_out("wr_visible", 4'h9, 4'h9, 3'b000);

      step(); we3 = 1'b1; wa3 = 4'd0; wd3 = 4'hF; ra1 = 4'd0; ra2 = 4'd3;
      expect_out("r0_write_cyc", 4'h0, 4'h9, 3'b000);
      step(); we3 = 1'b0;
      expect_out("r0_after", 4'h0, 4'h9, 3'b000);
      step();
      expect_out("r0_after2", 4'h0, 4'h9, 3'b000);
      for (int i = 1; i < 16; i++) begin
         step(); ra1 = 4'(i); ra2 = 4'(i);
         expect_out($sformatf("r0_others_R%0d", i), (i == 3) ? 4'h9 : 4'h0,
                    (i == 3) ? 4'h9 : 4'h0, 3'b000);
      end

      step(); we3 = 1'b1; wa3 = 4'd7; wd3 = 4'h6; ra1 = 4'd7; ra2 = 4'd3;
      expect_out("r7_write_cyc", 4'h0, 4'h9, 3'b000);
      for (int k = 0; k < 5; k++) begin
         step(); we3 = 1'b0; wd3 = (k % 2 == 0) ? 4'hF : 4'h1;
         expect_out($sformatf("hold_%0d", k), 4'h6, 4'h9, 3'b000);
      end

      step(); flags_we = 1'b1; zero_in = 1'b1; carry_in = 1'b1; sign_in = 1'b0;
      expect_out("flags_load_cyc", 4'h6, 4'h9, 3'b000);
      step(); flags_we = 1'b0; zero_in = 1'b0; carry_in = 1'b0; sign_in = 1'b1;
      expect_out("flags_loaded", 4'h6, 4'h9, 3'b110);
      step();
      expect_out("flags_hold", 4'h6, 4'h9, 3'b110);

      step(); we3 = 1'b1; flags_we = 1'b1; wa3 = 4'd15; wd3 = 4'h8;
      zero_in = 1'b0; carry_in = 1'b0; sign_in = 1'b1; ra1 = 4'd15; ra2 = 4'd7;
      expect_out("simul_cyc", 4'h0, 4'h6, 3'b110);
      step(); we3 = 1'b0; flags_we = 1'b0;
      expect_out("simul_after", 4'h8, 4'h6, 3'b001);

      for (int i = 1; i < 16; i++) begin
         step(); we3 = 1'b1; wa3 = 4'(i); wd3 = 4'(i); ra1 = 4'(i); ra2 = 4'(i);
         expect_out($sformatf("sweep_wr_R%0d", i), pre_sweep[i], pre_sweep[i], 3'b001);
      end
      step(); we3 = 1'b0;
      for (int i = 1; i < 16; i++) begin
         ra1 = 4'(i); ra2 = 4'(16 - i);
         expect_out($sformatf("sweep_rd_%0d", i), 4'(i), 4'(16 - i), 3'b001);
         step();
      end

      we3 = 1'b1; wa3 = 4'd5; wd3 = 4'hA; ra1 = 4'd5; ra2 = 4'd5;
      expect_out("r5_write_cyc", 4'h5, 4'h5, 3'b001);
      step(); we3 = 1'b0;
      expect_out("r5_written", 4'hA, 4'hA, 3'b001);
      step(); #2 reset = 1'b0;
      expect_out("async_reset", 4'h0, 4'h0, 3'b000);
      step(); we3 = 1'b1; wa3 = 4'd5; wd3 = 4'hC;
      expect_out("wr_in_reset", 4'h0, 4'h0, 3'b000);
      step(); reset = 1'b1; we3 = 1'b0;
      expect_out("wr_in_reset_lost", 4'h0, 4'h0, 3'b000);
      step(); we3 = 1'b1;
      expect_out("first_wr_cyc", 4'h0, 4'h0, 3'b000);
      step(); we3 = 1'b0;
      expect_out("first_wr_taken", 4'hC, 4'hC, 3'b000);

      for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations unconsumed, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
